// File: rtl/pmodi2s_pkg.sv
// Shared definitions for the I2S capture path.
// Holds the frame geometry and the receiver state encoding.
package pmodi2s_pkg;

  localparam int WORD_W   = 24;  // audio word width
  localparam int SLOT_W   = 32;  // SCK periods per channel slot
  localparam int SLOT_MIN = 25;  // shortest slot that still carries a full word
  localparam int SLOT_MAX = 63;  // SCK count with no LRCK edge that means a stuck LRCK

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer with a third stage for edge detection.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input pin
//   level    : synchronized level (second stage)
//   rise     : one-clk pulse on a synchronized 0->1 transition
//   fall     : one-clk pulse on a synchronized 1->0 transition
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pmodi2s_rx.sv
// I2S slave receiver: 64 SCK per frame, MSB first, one-SCK delay after
// each LRCK edge, LRCK low = left. Captures a left/right word pair per frame.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   sck        : external bit clock (asynchronous, <= clk/8)
//   lrck       : word select, 0 = left, 1 = right (asynchronous)
//   sdout      : serial data from the master (asynchronous)
//   data_l     : last complete left word, updated with data_valid
//   data_r     : last complete right word, updated with data_valid
//   data_valid : one-clk strobe when data_l/data_r are loaded as a pair
//   frame_err  : one-clk strobe on a short or stuck (over-long) slot
module pmodi2s_rx #(
  parameter int WORD_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              lrck,
  input  logic              sdout,
  output logic [WORD_W-1:0] data_l,
  output logic [WORD_W-1:0] data_r,
  output logic              data_valid,
  output logic              frame_err
);

  import pmodi2s_pkg::*;

  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(SLOT_MAX);
  localparam logic [CNT_W-1:0] CNT_PRE_SAT = CNT_W'(SLOT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MIN     = CNT_W'(SLOT_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WORD_W);

  logic sck_rise, sck_level_unused, sck_fall_unused;
  logic lrck_s, lrck_rise_unused, lrck_fall_unused;
  logic sd_s, sd_rise_unused, sd_fall_unused;

  i2s_sync_edge u_sync_sck (
    .clk(clk), .rst(rst), .d(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  i2s_sync_edge u_sync_lrck (
    .clk(clk), .rst(rst), .d(lrck),
    .level(lrck_s), .rise(lrck_rise_unused), .fall(lrck_fall_unused)
  );

  i2s_sync_edge u_sync_sd (
    .clk(clk), .rst(rst), .d(sdout),
    .level(sd_s), .rise(sd_rise_unused), .fall(sd_fall_unused)
  );

  // ---- stage 0: register the rise event with the levels sampled at it
  logic rise_p0, lrck_p0, sd_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_p0 <= 1'b0;
      lrck_p0 <= 1'b0;
      sd_p0   <= 1'b0;
    end else begin
      rise_p0 <= sck_rise;
      lrck_p0 <= lrck_s;
      sd_p0   <= sd_s;
    end
  end

  // ---- stage 1: slot tracking, FSM and deserialization on each rise
  rx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               lrck_prev;
  logic               primed;   // lrck_prev holds a real sample (first rise after reset only primes)
  logic               chg, short_slot, err_nxt, word_done, shift_en;
  logic [WORD_W-1:0]  shreg, hold;
  logic               vld_p1, err_p1;

  always_comb begin
    chg        = rise_p0 && primed && (lrck_p0 != lrck_prev);
    short_slot = chg && (state != SYNC) && (cnt < CNT_MIN);
    word_done  = rise_p0 && !chg && (cnt == CNT_LAST);
    shift_en   = rise_p0 && !chg && (cnt != '0) && (cnt <= CNT_LAST);
    state_nxt  = state;
    err_nxt    = 1'b0;
    if (chg) begin
      err_nxt = short_slot;
      // A falling LRCK always starts a left slot, even right after an error.
      if (!lrck_p0)
        state_nxt = LEFT;
      else if ((state == LEFT) && !short_slot)
        state_nxt = RIGHT;
      else
        state_nxt = SYNC;
    end else if (rise_p0 && (state != SYNC) && (cnt == CNT_PRE_SAT)) begin
      err_nxt   = 1'b1;
      state_nxt = SYNC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lrck_prev <= 1'b0;
      primed    <= 1'b0;
      shreg     <= '0;
      hold      <= '0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      if (rise_p0) begin
        lrck_prev <= lrck_p0;
        primed    <= 1'b1;
        if (chg)
          cnt <= CNT_W'(1);
        else if (cnt != CNT_SAT)
          cnt <= cnt + 1'b1;
      end
      if (shift_en)
        shreg <= {shreg[WORD_W-2:0], sd_p0};
      if (word_done && (state == LEFT))
        hold <= {shreg[WORD_W-2:0], sd_p0};
      // RIGHT is only reachable through a complete left slot, so the pair is intact.
      vld_p1 <= word_done && (state == RIGHT);
      err_p1 <= err_nxt;
    end
  end

  // ---- stage 2: strobe delay
  logic vld_p2, err_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      err_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      err_p2 <= err_p1;
    end
  end

  // ---- output stage: words load only together with the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_l     <= '0;
      data_r     <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= vld_p2;
      frame_err  <= err_p2;
      if (vld_p2) begin
        data_l <= hold;
        data_r <= shreg;
      end
    end
  end

endmodule
